// File: rtl/iob_axistream_in_pkg.sv
// rtl/iob_axistream_in_pkg.sv - shared sizing helpers for the stream-in core
// Provides lane count, lane counter width and FIFO entry width derived from
// the beat width. Entry layout: [31:0] data, [32 +: N] lane mask, [32+N] tlast.
package iob_axistream_in_pkg;

  localparam int WORD_W   = 32;
  localparam int MASK_LSB = WORD_W;

  function automatic int calc_lanes(input int tdata_w);
    return WORD_W / tdata_w;
  endfunction

  function automatic int calc_lane_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_entry_w(input int n);
    return WORD_W + n + 1;
  endfunction

endpackage

// File: rtl/iob_axistream_in_packer.sv
// rtl/iob_axistream_in_packer.sv - packs accepted beats little-endian into 32-bit words
// Ports:
//   clk_i, rst_i          clock, synchronous active-high clear (hard or soft reset)
//   beat_i                a beat is accepted this cycle
//   tdata_i, tlast_i      accepted beat data and end-of-packet flag
//   word_valid_o          word completes this cycle (combinational strobe)
//   word_data_o/mask_o    completed word including the current beat, unfilled lanes 0
//   word_last_o           completed word ends a packet
module iob_axistream_in_packer
  import iob_axistream_in_pkg::*;
#(
  parameter  int TDATA_W = 8,
  localparam int N       = calc_lanes(TDATA_W),
  localparam int CNT_W   = calc_lane_cnt_w(N)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               beat_i,
  input  logic [TDATA_W-1:0] tdata_i,
  input  logic               tlast_i,
  output logic               word_valid_o,
  output logic [WORD_W-1:0]  word_data_o,
  output logic [N-1:0]       word_mask_o,
  output logic               word_last_o
);

  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] part_data;
  logic [N-1:0]      part_mask;

  // The completed word merges the held partial lanes with the current beat so
  // the FIFO write can happen in the same cycle as the final beat.
  always_comb begin
    word_data_o = part_data;
    word_data_o[int'(cnt)*TDATA_W +: TDATA_W] = tdata_i;
    word_mask_o  = part_mask | (N'(1) << cnt);
    word_last_o  = tlast_i;
    word_valid_o = beat_i & (tlast_i | (cnt == CNT_W'(N-1)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt       <= '0;
      part_data <= '0;
      part_mask <= '0;
    end else if (beat_i) begin
      if (word_valid_o) begin
        cnt       <= '0;
        part_data <= '0;
        part_mask <= '0;
      end else begin
        cnt       <= cnt + CNT_W'(1);
        part_data <= word_data_o;
        part_mask <= word_mask_o;
      end
    end
  end

endmodule

// File: rtl/iob_axistream_in_core.sv
// rtl/iob_axistream_in_core.sv - AXI-Stream sink packing beats into a CPU-readable FIFO
// Ports:
//   clk_i, rst_i, soft_rst_i    clock, sync active-high hard reset, sync soft clear
//   enable_i                    stream accept enable
//   axis_tdata/tvalid/tlast_i   stream sink, axis_tready_o handshake
//   rd_en_i                     CPU pop; rdata_o/rstrb_o/rlast_o with rvalid_o one cycle later
//   empty_o, full_o, level_o    FIFO status (registered)
//   threshold_i, int_en_i       interrupt control; interrupt_o = int_en & level >= threshold
module iob_axistream_in_core
  import iob_axistream_in_pkg::*;
#(
  parameter  int TDATA_W         = 8,
  parameter  int FIFO_DEPTH_LOG2 = 4,
  localparam int N               = calc_lanes(TDATA_W)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     soft_rst_i,
  input  logic                     enable_i,
  input  logic [TDATA_W-1:0]       axis_tdata_i,
  input  logic                     axis_tvalid_i,
  input  logic                     axis_tlast_i,
  output logic                     axis_tready_o,
  input  logic                     rd_en_i,
  output logic [WORD_W-1:0]        rdata_o,
  output logic [N-1:0]             rstrb_o,
  output logic                     rlast_o,
  output logic                     rvalid_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [FIFO_DEPTH_LOG2:0] level_o,
  input  logic [FIFO_DEPTH_LOG2:0] threshold_i,
  input  logic                     int_en_i,
  output logic                     interrupt_o
);

  localparam int DEPTH    = 1 << FIFO_DEPTH_LOG2;
  localparam int ENTRY_W  = calc_entry_w(N);
  localparam int LAST_BIT = WORD_W + N;
  localparam int LW       = FIFO_DEPTH_LOG2 + 1;

  logic                       clr;
  logic                       accept;
  logic                       push;
  logic                       pop;
  logic [WORD_W-1:0]          word_data;
  logic [N-1:0]               word_mask;
  logic                       word_last;
  logic [ENTRY_W-1:0]         mem [DEPTH];
  logic [ENTRY_W-1:0]         rd_entry;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [LW-1:0]              level_next;

  assign clr           = rst_i | soft_rst_i;
  // Gating on full alone (not on a same-cycle pop) keeps push and the
  // registered full flag free of any read-to-write combinational path.
  assign axis_tready_o = enable_i & ~full_o & ~clr;
  assign accept        = axis_tvalid_i & axis_tready_o;
  assign pop           = rd_en_i & ~empty_o;
  assign rd_entry      = mem[rd_ptr];

  iob_axistream_in_packer #(
    .TDATA_W(TDATA_W)
  ) u_packer (
    .clk_i       (clk_i),
    .rst_i       (clr),
    .beat_i      (accept),
    .tdata_i     (axis_tdata_i),
    .tlast_i     (axis_tlast_i),
    .word_valid_o(push),
    .word_data_o (word_data),
    .word_mask_o (word_mask),
    .word_last_o (word_last)
  );

  always_comb begin
    level_next = level_o + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {word_last, word_mask, word_data};
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      empty_o     <= 1'b1;
      full_o      <= 1'b0;
      rdata_o     <= '0;
      rstrb_o     <= '0;
      rlast_o     <= 1'b0;
      rvalid_o    <= 1'b0;
      interrupt_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rdata_o <= rd_entry[WORD_W-1:0];
        rstrb_o <= rd_entry[MASK_LSB +: N];
        rlast_o <= rd_entry[LAST_BIT];
      end
      rvalid_o    <= pop;
      level_o     <= level_next;
      empty_o     <= (level_next == '0);
      full_o      <= (level_next == LW'(DEPTH));
      // Uses the registered level, so it lags a level change by one cycle.
      interrupt_o <= int_en_i & (level_o >= threshold_i);
    end
  end

endmodule

// File: tb/tb_iob_axistream_in_core.sv
// tb/tb_iob_axistream_in_core.sv - directed self-checking bench for iob_axistream_in_core
module tb_iob_axistream_in_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        soft_rst;
  logic        enable;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic        rd_en;
  logic [31:0] rdata;
  logic [3:0]  rstrb;
  logic        rlast;
  logic        rvalid;
  logic        empty;
  logic        full;
  logic [2:0]  level;
  logic [2:0]  threshold;
  logic        int_en;
  logic        interrupt;

  logic        b_soft_rst;
  logic        b_enable;
  logic [31:0] b_tdata;
  logic        b_tvalid;
  logic        b_tlast;
  logic        b_tready;
  logic        b_rd_en;
  logic [31:0] b_rdata;
  logic [0:0]  b_rstrb;
  logic        b_rlast;
  logic        b_rvalid;
  logic        b_empty;
  logic        b_full;
  logic [2:0]  b_level;
  logic [2:0]  b_threshold;
  logic        b_int_en;
  logic        b_interrupt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iob_axistream_in_core #(.TDATA_W(8), .FIFO_DEPTH_LOG2(2)) dut (
    .clk_i(clk), .rst_i(rst), .soft_rst_i(soft_rst), .enable_i(enable),
    .axis_tdata_i(tdata), .axis_tvalid_i(tvalid), .axis_tlast_i(tlast),
    .axis_tready_o(tready), .rd_en_i(rd_en), .rdata_o(rdata), .rstrb_o(rstrb),
    .rlast_o(rlast), .rvalid_o(rvalid), .empty_o(empty), .full_o(full),
    .level_o(level), .threshold_i(threshold), .int_en_i(int_en),
    .interrupt_o(interrupt)
  );

  iob_axistream_in_core #(.TDATA_W(32), .FIFO_DEPTH_LOG2(2)) dut_w32 (
    .clk_i(clk), .rst_i(rst), .soft_rst_i(b_soft_rst), .enable_i(b_enable),
    .axis_tdata_i(b_tdata), .axis_tvalid_i(b_tvalid), .axis_tlast_i(b_tlast),
    .axis_tready_o(b_tready), .rd_en_i(b_rd_en), .rdata_o(b_rdata), .rstrb_o(b_rstrb),
    .rlast_o(b_rlast), .rvalid_o(b_rvalid), .empty_o(b_empty), .full_o(b_full),
    .level_o(b_level), .threshold_i(b_threshold), .int_en_i(b_int_en),
    .interrupt_o(b_interrupt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] d, input logic [3:0] s,
                           input logic l);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, rdata, d);
    check({tag, "_rstrb"}, 32'(rstrb), 32'(s));
    check({tag, "_rlast"}, 32'(rlast), 32'(l));
    tick();
    check({tag, "_rvalid_pulse"}, 32'(rvalid), 32'd0);
    check({tag, "_rdata_hold"}, rdata, d);
  endtask

  initial begin
    rst = 1'b1; soft_rst = 1'b0; enable = 1'b1;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0; rd_en = 1'b0;
    threshold = 3'd0; int_en = 1'b0;
    b_soft_rst = 1'b0; b_enable = 1'b1; b_tdata = '0; b_tvalid = 1'b0;
    b_tlast = 1'b0; b_rd_en = 1'b0; b_threshold = 3'd0; b_int_en = 1'b0;

    // Reset state (enable already high: tready must still be low in reset)
    tick();
    tick();
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rstrb", 32'(rstrb), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_int", 32'(interrupt), 32'd0);
    rst = 1'b0;
    #1;
    check("tready_after_rst", 32'(tready), 32'd1);

    // 1: full word with tlast
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    check("t1_level_partial", 32'(level), 32'd0);
    send(8'h44, 1'b1);
    check("t1_level", 32'(level), 32'd1);
    check("t1_empty", 32'(empty), 32'd0);
    pop_check("t1", 32'h44332211, 4'hF, 1'b1);
    check("t1_empty_after", 32'(empty), 32'd1);

    // 2: short packet, then next word starts at lane 0
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    pop_check("t2a", 32'h0000BBAA, 4'h3, 1'b1);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    pop_check("t2b", 32'h04030201, 4'hF, 1'b0);

    // 3: fill to full, back-pressure, pop one, resume
    tvalid = 1'b1;
    tlast  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tdata = 8'(8'h10 + i);
      tick();
    end
    tdata = 8'hA0;
    check("t3_full", 32'(full), 32'd1);
    check("t3_level", 32'(level), 32'd4);
    check("t3_tready", 32'(tready), 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t3_pop_rvalid", 32'(rvalid), 32'd1);
    check("t3_pop_rdata", rdata, 32'h13121110);
    check("t3_level_after_pop", 32'(level), 32'd3);
    check("t3_tready_back", 32'(tready), 32'd1);
    tick();
    tdata = 8'hA1;
    tick();
    tdata = 8'hA2;
    tick();
    tdata = 8'hA3;
    tick();
    tvalid = 1'b0;
    check("t3_refull_level", 32'(level), 32'd4);
    pop_check("t3w1", 32'h17161514, 4'hF, 1'b0);
    pop_check("t3w2", 32'h1B1A1918, 4'hF, 1'b0);
    pop_check("t3w3", 32'h1F1E1D1C, 4'hF, 1'b0);
    pop_check("t3w4", 32'hA3A2A1A0, 4'hF, 1'b0);
    check("t3_empty", 32'(empty), 32'd1);

    // 4: soft reset discards stored and partial words
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hC4, 1'b0);
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    check("t4_level_before", 32'(level), 32'd1);
    soft_rst = 1'b1;
    #1;
    check("t4_tready_srst", 32'(tready), 32'd0);
    tick();
    soft_rst = 1'b0;
    check("t4_level", 32'(level), 32'd0);
    check("t4_empty", 32'(empty), 32'd1);
    check("t4_rdata_clr", rdata, 32'd0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    pop_check("t4", 32'h04030201, 4'hF, 1'b0);

    // 5: interrupt threshold
    threshold = 3'd2;
    int_en    = 1'b1;
    send(8'h77, 1'b1);
    check("t5_int_l1", 32'(interrupt), 32'd0);
    send(8'h88, 1'b1);
    check("t5_level2", 32'(level), 32'd2);
    check("t5_int_lag", 32'(interrupt), 32'd0);
    tick();
    check("t5_int_rise", 32'(interrupt), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t5_pop_rdata", rdata, 32'h00000077);
    check("t5_pop_rstrb", 32'(rstrb), 32'h1);
    check("t5_pop_rlast", 32'(rlast), 32'd1);
    check("t5_int_hold", 32'(interrupt), 32'd1);
    tick();
    check("t5_int_fall", 32'(interrupt), 32'd0);
    pop_check("t5b", 32'h00000088, 4'h1, 1'b1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t5_empty_rd_rvalid", 32'(rvalid), 32'd0);
    check("t5_empty_rd_rdata", rdata, 32'h00000088);
    check("t5_empty_rd_level", 32'(level), 32'd0);

    // 6: 32-bit beats, one entry per beat
    b_tvalid = 1'b1;
    b_tdata  = 32'hDEADBEEF;
    b_tlast  = 1'b0;
    tick();
    b_tdata  = 32'h12345678;
    b_tlast  = 1'b1;
    tick();
    b_tvalid = 1'b0;
    b_tlast  = 1'b0;
    check("t6_level", 32'(b_level), 32'd2);
    b_rd_en = 1'b1;
    tick();
    check("t6_w1_rvalid", 32'(b_rvalid), 32'd1);
    check("t6_w1_rdata", b_rdata, 32'hDEADBEEF);
    check("t6_w1_rstrb", 32'(b_rstrb), 32'd1);
    check("t6_w1_rlast", 32'(b_rlast), 32'd0);
    tick();
    b_rd_en = 1'b0;
    check("t6_w2_rvalid", 32'(b_rvalid), 32'd1);
    check("t6_w2_rdata", b_rdata, 32'h12345678);
    check("t6_w2_rlast", 32'(b_rlast), 32'd1);
    check("t6_empty", 32'(b_empty), 32'd1);
    b_rd_en = 1'b1;
    tick();
    b_rd_en = 1'b0;
    check("t6_empty_rd_rvalid", 32'(b_rvalid), 32'd0);
    check("t6_empty_rd_rdata", b_rdata, 32'h12345678);
    check("t6_empty_rd_level", 32'(b_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
